// File: rtl/ravenoc_link_slice.sv
// ravenoc_link_slice
//   Registered link slice for one NoC hop. Each virtual channel has its own
//   2-entry FIFO. The output side offers the head of the highest-numbered VC
//   that is both non-empty and ready downstream.
//
// Ports
//   clk_noc     in   NoC clock, rising edge
//   arst_noc    in   asynchronous reset, active low
//   in_valid    in   upstream flit valid
//   in_vc_id    in   upstream flit VC
//   in_fdata    in   upstream flit data
//   in_ready    out  per-VC space available (from registers only)
//   out_valid   out  downstream flit valid
//   out_vc_id   out  downstream flit VC
//   out_fdata   out  downstream flit data
//   out_ready   in   per-VC downstream readiness
//   overflow_o  out  sticky: flit arrived for a full VC and was dropped
//   bad_vc_o    out  sticky: flit arrived with VC id >= N_VIRT_CHN and was dropped
//
// Handshake
//   Upstream: a flit transfers on an edge with in_valid=1, a legal in_vc_id
//   and in_ready[in_vc_id]=1. in_valid with in_ready[in_vc_id]=0 is not a
//   stall; the flit is lost and overflow_o is raised.
//   Downstream: out_ready is pre-qualified per VC, so any cycle with
//   out_valid=1 is a completed transfer and the head pops on that edge.

module ravenoc_link_slice #(
  parameter int FLIT_WIDTH = 34,
  parameter int N_VIRT_CHN = 3
) (
  input  logic                          clk_noc,
  input  logic                          arst_noc,
  input  logic                          in_valid,
  input  logic [$clog2(N_VIRT_CHN)-1:0] in_vc_id,
  input  logic [FLIT_WIDTH-1:0]         in_fdata,
  output logic [N_VIRT_CHN-1:0]         in_ready,
  output logic                          out_valid,
  output logic [$clog2(N_VIRT_CHN)-1:0] out_vc_id,
  output logic [FLIT_WIDTH-1:0]         out_fdata,
  input  logic [N_VIRT_CHN-1:0]         out_ready,
  output logic                          overflow_o,
  output logic                          bad_vc_o
);

  localparam int VC_W = $clog2(N_VIRT_CHN);

  // Storage is not reset: out_fdata is masked whenever a FIFO is empty.
  logic [FLIT_WIDTH-1:0] r_mem [N_VIRT_CHN][2];
  logic [N_VIRT_CHN-1:0] r_rd_ptr;
  logic [N_VIRT_CHN-1:0] r_wr_ptr;
  logic [1:0]            r_cnt [N_VIRT_CHN];
  logic                  r_overflow;
  logic                  r_bad_vc;

  logic [N_VIRT_CHN-1:0] w_push;
  logic [N_VIRT_CHN-1:0] w_pop;
  logic [N_VIRT_CHN-1:0] w_elig;
  logic                  w_any;
  logic                  w_vc_legal;
  logic                  w_hit_full;
  logic [VC_W-1:0]       w_sel;
  logic [FLIT_WIDTH-1:0] w_head;

  always_comb begin
    in_ready   = '0;
    w_push     = '0;
    w_pop      = '0;
    w_elig     = '0;
    w_any      = 1'b0;
    w_hit_full = 1'b0;
    w_sel      = '0;
    w_head     = '0;
    w_vc_legal = (int'(in_vc_id) < N_VIRT_CHN);

    for (int v = 0; v < N_VIRT_CHN; v++) begin
      in_ready[v] = (r_cnt[v] != 2'd2);
      w_elig[v]   = (r_cnt[v] != 2'd0) && out_ready[v];
      // Ascending scan: the last eligible VC seen is the highest one.
      if (w_elig[v]) begin
        w_any = 1'b1;
        w_sel = VC_W'(v);
      end
      // Fullness is judged on the registered count, so a push into a full
      // VC is dropped even if that VC pops on the same edge.
      if (in_valid && (in_vc_id == VC_W'(v))) begin
        if (r_cnt[v] != 2'd2) w_push[v] = 1'b1;
        else                  w_hit_full = 1'b1;
      end
    end

    for (int v = 0; v < N_VIRT_CHN; v++) begin
      w_pop[v] = w_any && (w_sel == VC_W'(v));
      if (w_pop[v]) w_head = r_mem[v][r_rd_ptr[v]];
    end
  end

  assign out_valid  = w_any;
  assign out_vc_id  = w_sel;
  assign out_fdata  = w_head;
  assign overflow_o = r_overflow;
  assign bad_vc_o   = r_bad_vc;

  always_ff @(posedge clk_noc or negedge arst_noc) begin
    if (!arst_noc) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_overflow <= 1'b0;
      r_bad_vc   <= 1'b0;
      for (int v = 0; v < N_VIRT_CHN; v++) r_cnt[v] <= 2'd0;
    end else begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
        if (w_push[v]) r_wr_ptr[v] <= ~r_wr_ptr[v];
        if (w_pop[v])  r_rd_ptr[v] <= ~r_rd_ptr[v];
        case ({w_push[v], w_pop[v]})
          2'b10:   r_cnt[v] <= r_cnt[v] + 2'd1;
          2'b01:   r_cnt[v] <= r_cnt[v] - 2'd1;
          default: r_cnt[v] <= r_cnt[v];
        endcase
      end
      if (w_hit_full)              r_overflow <= 1'b1;
      if (in_valid && !w_vc_legal) r_bad_vc   <= 1'b1;
    end
  end

  always_ff @(posedge clk_noc) begin
    for (int v = 0; v < N_VIRT_CHN; v++) begin
      if (w_push[v]) r_mem[v][r_wr_ptr[v]] <= in_fdata;
    end
  end

endmodule

// File: tb/tb_ravenoc_link_slice.sv
module tb_ravenoc_link_slice;

  localparam int FW = 34;
  localparam int NV = 3;
  localparam int VW = 2;

  logic          clk_noc;
  logic          arst_noc;
  logic          in_valid;
  logic [VW-1:0] in_vc_id;
  logic [FW-1:0] in_fdata;
  logic [NV-1:0] in_ready;
  logic          out_valid;
  logic [VW-1:0] out_vc_id;
  logic [FW-1:0] out_fdata;
  logic [NV-1:0] out_ready;
  logic          overflow_o;
  logic          bad_vc_o;

  int checks = 0;
  int errors = 0;

  // Reference model: all buffered flits in arrival order, each tagged with
  // its VC. Per-VC FIFO order is the relative order within this list.
  logic [FW-1:0] exp_q[$];
  int            exp_vc[$];
  logic          m_ovf;
  logic          m_bad;

  ravenoc_link_slice #(.FLIT_WIDTH(FW), .N_VIRT_CHN(NV)) dut (
    .clk_noc   (clk_noc),
    .arst_noc  (arst_noc),
    .in_valid  (in_valid),
    .in_vc_id  (in_vc_id),
    .in_fdata  (in_fdata),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_vc_id (out_vc_id),
    .out_fdata (out_fdata),
    .out_ready (out_ready),
    .overflow_o(overflow_o),
    .bad_vc_o  (bad_vc_o)
  );

  // clock / watchdog
  initial clk_noc = 1'b0;
  always #5 clk_noc = ~clk_noc;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_vc(input int v);
    int n = 0;
    foreach (exp_vc[i]) if (exp_vc[i] == v) n++;
    return n;
  endfunction

  function automatic int first_idx(input int v);
    for (int i = 0; i < exp_vc.size(); i++) if (exp_vc[i] == v) return i;
    return -1;
  endfunction

  // Highest-index VC with data and downstream readiness.
  task automatic predict(output logic e_v, output int e_sel, output logic [FW-1:0] e_d);
    e_v = 1'b0; e_sel = 0; e_d = '0;
    for (int v = NV - 1; v >= 0; v--) begin
      if (!e_v && out_ready[v] && count_vc(v) > 0) begin
        e_v = 1'b1; e_sel = v; e_d = exp_q[first_idx(v)];
      end
    end
  endtask

  task automatic check_outputs();
    logic [NV-1:0] e_rdy;
    logic e_v; int e_sel; logic [FW-1:0] e_d;
    e_rdy = '0;
    for (int v = 0; v < NV; v++) e_rdy[v] = (count_vc(v) < 2);
    predict(e_v, e_sel, e_d);
    chk("in_ready",  64'(in_ready),   64'(e_rdy));
    chk("out_valid", 64'(out_valid),  64'(e_v));
    chk("out_vc_id", 64'(out_vc_id),  64'(e_sel));
    chk("out_fdata", 64'(out_fdata),  64'(e_d));
    chk("overflow",  64'(overflow_o), 64'(m_ovf));
    chk("bad_vc",    64'(bad_vc_o),   64'(m_bad));
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  task automatic model_update();
    logic e_v; int e_sel; logic [FW-1:0] e_d;
    int vc_i, pre;
    vc_i = int'(in_vc_id);
    pre  = (vc_i < NV) ? count_vc(vc_i) : 0;
    predict(e_v, e_sel, e_d);
    if (e_v) begin
      int k = first_idx(e_sel);
      exp_q.delete(k);
      exp_vc.delete(k);
    end
    if (in_valid) begin
      if (vc_i >= NV)    m_bad = 1'b1;
      else if (pre == 2) m_ovf = 1'b1;
      else begin
        exp_q.push_back(in_fdata);
        exp_vc.push_back(vc_i);
      end
    end
  endtask

  // driver: called at posedge+1, returns at the next posedge+1
  task automatic cyc(input logic iv, input int vc, input logic [FW-1:0] d, input logic [NV-1:0] ordy);
    in_valid  = iv;
    in_vc_id  = VW'(vc);
    in_fdata  = d;
    out_ready = ordy;
    #1;
    check_outputs();
    model_update();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    arst_noc = 1'b0;
    #2;
    chk("rst_in_ready",  64'(in_ready),  64'(3'b111));
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_vc_id", 64'(out_vc_id), 64'd0);
    chk("rst_out_fdata", 64'(out_fdata), 64'd0);
    exp_q.delete();
    exp_vc.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
    check_outputs();
    @(posedge clk_noc);
    #3;
    arst_noc = 1'b1;
    #1;
  endtask

  initial begin
    arst_noc  = 1'b0;
    in_valid  = 1'b0;
    in_vc_id  = '0;
    in_fdata  = '0;
    out_ready = '0;
    m_ovf     = 1'b0;
    m_bad     = 1'b0;
    @(posedge clk_noc);
    #1;
    do_reset();

    // single flit on VC0, pushed on the first edge after reset release
    cyc(1'b1, 0, 34'h1, 3'b001);
    chk("s1_valid", 64'(out_valid), 64'd1);
    chk("s1_data",  64'(out_fdata), 64'h1);
    cyc(1'b0, 0, '0, 3'b001);
    chk("s1_empty", 64'(out_valid), 64'd0);
    cyc(1'b0, 0, '0, 3'b001);

    // fill VC1, overflow with a third flit, then drain
    do_reset();
    cyc(1'b1, 1, 34'h0AAAA, 3'b000);
    cyc(1'b1, 1, 34'h0BBBB, 3'b000);
    chk("s2_full", 64'(in_ready[1]), 64'd0);
    cyc(1'b1, 1, 34'h0CCCC, 3'b000);
    chk("s2_ovf",  64'(overflow_o), 64'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, '0, 3'b010);

    // priority: VC2 wins over VC0
    do_reset();
    cyc(1'b1, 0, 34'h10, 3'b000);
    cyc(1'b1, 0, 34'h11, 3'b000);
    cyc(1'b1, 2, 34'h20, 3'b000);
    cyc(1'b1, 2, 34'h21, 3'b000);
    cyc(1'b0, 0, '0, 3'b111);
    chk("s3_vc2", 64'(out_vc_id), 64'd2);
    cyc(1'b0, 0, '0, 3'b111);
    chk("s3_vc0", 64'(out_vc_id), 64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, '0, 3'b111);

    // VC0 drains while blocked VC2 holds both flits
    do_reset();
    cyc(1'b1, 0, 34'h30, 3'b000);
    cyc(1'b1, 2, 34'h40, 3'b000);
    cyc(1'b1, 0, 34'h31, 3'b000);
    cyc(1'b1, 2, 34'h41, 3'b000);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, '0, 3'b001);
    chk("s4_vc2_held", 64'(in_ready[2]), 64'd0);
    chk("s4_idle",     64'(out_valid),   64'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, '0, 3'b100);

    // illegal VC id
    do_reset();
    cyc(1'b1, 3, 34'h55, 3'b111);
    chk("s5_bad",   64'(bad_vc_o), 64'd1);
    chk("s5_nochg", 64'(in_ready), 64'(3'b111));
    for (int i = 0; i < 100; i++) cyc(1'b0, 0, '0, 3'b111);
    chk("s5_bad_held", 64'(bad_vc_o), 64'd1);

    // 1000-flit stream on VC1 with random resets
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      cyc(1'b1, 1, {$urandom(), 2'(i)}, 3'b010);
    end

    // random mixed traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int vc;
      if ($urandom_range(0, 99) == 0) do_reset();
      vc = ($urandom_range(0, 31) == 0) ? 3 : int'($urandom_range(0, NV - 1));
      cyc($urandom_range(0, 3) != 0, vc, {$urandom(), 2'($urandom())}, NV'($urandom()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
